// File: rtl/mac_pkg.sv
// mac_pkg: shared FSM state type, array geometry and default latencies for the MAC array sequencer.
package mac_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, FLUSH, DRAIN, ZDONE} state_t;
  localparam int ARRAY_ROWS = 32;
  localparam int ARRAY_COLS = 32;
  localparam int OPERAND_W = 8;
  localparam int RESULT_W = 16;
  localparam int DEF_RD_LAT = 1;
  localparam int DEF_ARRAY_LAT = 1;
endpackage

// File: rtl/mac_seq_delay.sv
// mac_seq_delay: DEPTH-stage shift register aligning array controls with operand buffer read latency.
module mac_seq_delay #(
  parameter int DEPTH = 1,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         pend
);
  logic [DEPTH-1:0][W-1:0] q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else begin
      for (int i = DEPTH - 1; i > 0; i--) q[i] <= q[i-1];
      q[0] <= din;
    end
  assign dout = q[DEPTH-1];
  // pend: something is still on its way to dout in a later cycle
  always_comb begin
    pend = |din;
    for (int i = 0; i < DEPTH - 1; i++) pend = pend | (|q[i]);
  end
endmodule

// File: rtl/mac_array_seq.sv
// mac_array_seq: job sequencer streaming K operand reads into the MAC array and handing the result to writeback.
module mac_array_seq
  import mac_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int K_W = 16,
  parameter int RD_LAT = DEF_RD_LAT,
  parameter int ARRAY_LAT = DEF_ARRAY_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [K_W-1:0]    cmd_k,
  input  logic [ADDR_W-1:0] cmd_a_base,
  input  logic [ADDR_W-1:0] cmd_b_base,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_a_addr,
  output logic [ADDR_W-1:0] rd_b_addr,
  output logic              mac_en,
  output logic              mac_clr,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic              done
);
  localparam logic [3:0] FC_LAST = 4'(ARRAY_LAT - 1);
  state_t         state;
  logic [K_W-1:0] k;
  logic [K_W-1:0] cnt;
  logic [3:0]     fc;
  logic           pend;
  mac_seq_delay #(.DEPTH(RD_LAT), .W(2)) u_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({rd_en, rd_en && (cnt == '0)}),
    .dout ({mac_en, mac_clr}),
    .pend (pend)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      cnt       <= '0;
      fc        <= '0;
      rd_en     <= 1'b0;
      rd_a_addr <= '0;
      rd_b_addr <= '0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b0;
    end else
      case (state)
        IDLE: begin
          done      <= 1'b0;
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            k         <= cmd_k;
            cnt       <= '0;
            fc        <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_k == '0) begin
              state <= ZDONE;
              done  <= 1'b1;
            end else begin
              state     <= ISSUE;
              rd_en     <= 1'b1;
              rd_a_addr <= cmd_a_base;
              rd_b_addr <= cmd_b_base;
            end
          end
        end
        ISSUE:
          if (cnt == k - K_W'(1)) begin
            rd_en <= 1'b0;
            state <= FLUSH;
          end else begin
            cnt       <= cnt + K_W'(1);
            rd_a_addr <= rd_a_addr + ADDR_W'(1);
            rd_b_addr <= rd_b_addr + ADDR_W'(1);
          end
        // counting starts on the last mac_en cycle, once nothing is left upstream of it
        FLUSH:
          if (!pend) begin
            if (fc == FC_LAST) begin
              state     <= DRAIN;
              res_valid <= 1'b1;
            end else fc <= fc + 4'd1;
          end
        DRAIN:
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            done      <= 1'b1;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        ZDONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_mac_array_seq.sv
// tb_mac_array_seq: two sequencer instances with different latencies driven in lockstep against a cycle-schedule model.
module tb_mac_array_seq;
  localparam int RL0 = 1, AL0 = 1, RL1 = 3, AL1 = 4;
  logic clk = 0, rst_n = 0, cmd_valid = 0, res_ready = 0;
  logic [15:0] cmd_k = '0;
  logic [11:0] cmd_a_base = '0, cmd_b_base = '0;
  logic cr [2], rd [2], me [2], mc [2], rv [2], bz [2], dn [2];
  logic [11:0] ra [2], rb [2];
  int n_cmp = 0, n_err = 0;
  logic [6:0] ob [2][128];
  logic [11:0] oa [2][128], obb [2][128];

  always #5 clk = ~clk;

  mac_array_seq #(.ADDR_W(12), .K_W(16), .RD_LAT(RL0), .ARRAY_LAT(AL0)) dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cr[0]), .cmd_k(cmd_k),
    .cmd_a_base(cmd_a_base), .cmd_b_base(cmd_b_base), .rd_en(rd[0]), .rd_a_addr(ra[0]),
    .rd_b_addr(rb[0]), .mac_en(me[0]), .mac_clr(mc[0]), .res_valid(rv[0]),
    .res_ready(res_ready), .busy(bz[0]), .done(dn[0]));
  mac_array_seq #(.ADDR_W(12), .K_W(16), .RD_LAT(RL1), .ARRAY_LAT(AL1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cr[1]), .cmd_k(cmd_k),
    .cmd_a_base(cmd_a_base), .cmd_b_base(cmd_b_base), .rd_en(rd[1]), .rd_a_addr(ra[1]),
    .rd_b_addr(rb[1]), .mac_en(me[1]), .mac_clr(mc[1]), .res_valid(rv[1]),
    .res_ready(res_ready), .busy(bz[1]), .done(dn[1]));

  function automatic int rl(int i); return i != 0 ? RL1 : RL0; endfunction
  function automatic int al(int i); return i != 0 ? AL1 : AL0; endfunction

  // cycle in which the result is consumed: first cycle >= ready-time with res_ready high
  function automatic int t_take(int i, int k, int r);
    int v;
    v = k + rl(i) + al(i);
    return v > r ? v : r;
  endfunction

  function automatic int e_end(int i, int k, int r);
    return k == 0 ? 2 : t_take(i, k, r) + 2;
  endfunction

  // expected {cmd_ready,busy,done,res_valid,mac_clr,mac_en,rd_en} in cycle c after acceptance
  function automatic logic [6:0] exp_sig(int i, int k, int r, bit hold, int c);
    int e;
    if (k == 0) return {c >= 2, c == 1, c == 1, 4'b0000};
    e = t_take(i, k, r);
    return {c == e + 1 || (!hold && c > e + 1),
            c <= e || (hold && c == e + 2),
            c == e + 1,
            c >= k + rl(i) + al(i) && c <= e,
            c == 1 + rl(i),
            c >= 1 + rl(i) && c <= k + rl(i),
            c <= k || (hold && c == e + 2)};
  endfunction

  task automatic settle;
    int t;
    t = 0;
    cmd_valid = 0;
    res_ready = 1;
    @(negedge clk);
    while (!(cr[0] && cr[1] && !bz[0] && !bz[1]) && t < 400) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 400) begin
      n_err++;
      $display("FAIL settle: sequencers still busy after %0d cycles (required idle)", t);
    end
  endtask

  task automatic run_trace(int k, logic [11:0] a, logic [11:0] b, int r, bit hold);
    int n, n1;
    settle;
    n = e_end(0, k, r);
    n1 = e_end(1, k, r);
    if (n1 > n) n = n1;
    cmd_k = 16'(k);
    cmd_a_base = a;
    cmd_b_base = b;
    cmd_valid = 1;
    res_ready = (r <= 0);
    @(posedge clk);
    #1;
    cmd_valid = hold;
    if (!hold) begin
      cmd_k = 16'($urandom);
      cmd_a_base = 12'($urandom);
      cmd_b_base = 12'($urandom);
    end
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        ob[i][c] = {cr[i], bz[i], dn[i], rv[i], mc[i], me[i], rd[i]};
        oa[i][c] = ra[i];
        obb[i][c] = rb[i];
      end
      res_ready = (c >= r);
    end
    cmd_valid = 0;
  endtask

  task automatic test_reset;
    #13;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({cr[i], bz[i], dn[i], rv[i], mc[i], me[i], rd[i], ra[i], rb[i]} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs inst%0d: got %b %h %h, required all zero", i,
                 {cr[i], bz[i], dn[i], rv[i], mc[i], me[i], rd[i]}, ra[i], rb[i]);
      end
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({cr[i], bz[i], dn[i]} !== 3'b100) begin
        n_err++;
        $display("FAIL post_reset inst%0d: {cmd_ready,busy,done} got %b required 100", i, {cr[i], bz[i], dn[i]});
      end
    end
  endtask

  task automatic test_directed;
    int ks [3] = '{4, 0, 4};
    logic [11:0] as [3] = '{12'h010, 12'h123, 12'hFFE};
    logic [11:0] bs [3] = '{12'h200, 12'h456, 12'h7F0};
    for (int j = 0; j < 3; j++) begin
      run_trace(ks[j], as[j], bs[j], 0, 0);
      for (int i = 0; i < 2; i++)
        for (int c = 1; c <= e_end(i, ks[j], 0); c++) begin
          logic [6:0] e;
          e = exp_sig(i, ks[j], 0, 0, c);
          n_cmp++;
          if (ob[i][c] !== e) begin
            n_err++;
            $display("FAIL directed%0d inst%0d cyc%0d ctl: got %b required %b", j, i, c, ob[i][c], e);
          end
          if (c <= ks[j]) begin
            n_cmp++;
            if (oa[i][c] !== 12'(as[j] + c - 1) || obb[i][c] !== 12'(bs[j] + c - 1)) begin
              n_err++;
              $display("FAIL directed%0d inst%0d cyc%0d addr: got %h/%h required %h/%h", j, i, c,
                       oa[i][c], obb[i][c], 12'(as[j] + c - 1), 12'(bs[j] + c - 1));
            end
          end
        end
    end
  endtask

  task automatic test_backpressure;
    int r;
    logic [11:0] a, b;
    r = 2 + RL0 + AL0 + 5;
    a = 12'($urandom);
    b = 12'($urandom);
    run_trace(2, a, b, r, 1);
    for (int i = 0; i < 2; i++)
      for (int c = 1; c <= e_end(i, 2, r); c++) begin
        logic [6:0] e;
        e = exp_sig(i, 2, r, 1, c);
        n_cmp++;
        if (ob[i][c] !== e) begin
          n_err++;
          $display("FAIL backpressure inst%0d cyc%0d ctl: got %b required %b", i, c, ob[i][c], e);
        end
        if (c <= 2) begin
          n_cmp++;
          if (oa[i][c] !== 12'(a + c - 1) || obb[i][c] !== 12'(b + c - 1)) begin
            n_err++;
            $display("FAIL backpressure inst%0d cyc%0d addr: got %h/%h", i, c, oa[i][c], obb[i][c]);
          end
        end
      end
  endtask

  task automatic test_reset_mid;
    logic [11:0] a, b;
    settle;
    cmd_k = 16'd8;
    cmd_a_base = 12'($urandom);
    cmd_b_base = 12'($urandom);
    cmd_valid = 1;
    @(posedge clk);
    #1;
    cmd_valid = 0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({cr[i], bz[i], dn[i], rv[i], mc[i], me[i], rd[i], ra[i], rb[i]} !== '0) begin
        n_err++;
        $display("FAIL midjob_reset inst%0d: got %b %h %h, required all zero", i,
                 {cr[i], bz[i], dn[i], rv[i], mc[i], me[i], rd[i]}, ra[i], rb[i]);
      end
    end
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({cr[i], bz[i], dn[i], me[i]} !== 4'b1000) begin
        n_err++;
        $display("FAIL after_mid_reset inst%0d: {cmd_ready,busy,done,mac_en} got %b required 1000", i,
                 {cr[i], bz[i], dn[i], me[i]});
      end
    end
    a = 12'($urandom);
    b = 12'($urandom);
    run_trace(1, a, b, 0, 0);
    for (int i = 0; i < 2; i++)
      for (int c = 1; c <= e_end(i, 1, 0); c++) begin
        logic [6:0] e;
        e = exp_sig(i, 1, 0, 0, c);
        n_cmp++;
        if (ob[i][c] !== e) begin
          n_err++;
          $display("FAIL rerun_k1 inst%0d cyc%0d ctl: got %b required %b", i, c, ob[i][c], e);
        end
      end
  endtask

  task automatic test_random;
    int k, r;
    bit hold;
    logic [11:0] a, b;
    repeat (25) begin
      k = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 20));
      r = $urandom_range(0, 30);
      hold = (k > 0) && ($urandom_range(0, 3) == 0);
      a = 12'($urandom);
      b = 12'($urandom);
      run_trace(k, a, b, r, hold);
      for (int i = 0; i < 2; i++)
        for (int c = 1; c <= e_end(i, k, r); c++) begin
          logic [6:0] e;
          e = exp_sig(i, k, r, hold, c);
          n_cmp++;
          if (ob[i][c] !== e) begin
            n_err++;
            $display("FAIL random k=%0d r=%0d hold=%0d inst%0d cyc%0d ctl: got %b required %b",
                     k, r, hold, i, c, ob[i][c], e);
          end
          if (c <= k) begin
            n_cmp++;
            if (oa[i][c] !== 12'(a + c - 1) || obb[i][c] !== 12'(b + c - 1)) begin
              n_err++;
              $display("FAIL random k=%0d inst%0d cyc%0d addr: got %h/%h required %h/%h", k, i, c,
                       oa[i][c], obb[i][c], 12'(a + c - 1), 12'(b + c - 1));
            end
          end
        end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
